// File: rtl/simple_cpu_mc.sv
// Multi-cycle CPU core: IDLE/DECODE/EXEC/MEM/WB with valid/ready instruction intake, regfile, data memory.
// Optional macro SIMPLE_CPU_FLAGS_EN builds the zero/carry flag registers; otherwise both flags read 0.
module simple_cpu_mc #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BITS   = 5,
  parameter int INSTR_WIDTH = 20,
  parameter int REG_BITS    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic                   retire,
  input  logic [REG_BITS-1:0]    dbg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_data,
  output logic                   zero_flag,
  output logic                   carry_flag
);

  localparam int NREGS  = 2 ** REG_BITS;
  localparam int DEPTH  = 2 ** ADDR_BITS;
  localparam int X3_LSB = 4 + DATA_WIDTH;
  localparam int X2_LSB = X3_LSB + REG_BITS;
  localparam int X1_LSB = X2_LSB + REG_BITS;
  localparam int OP_LSB = X1_LSB + REG_BITS;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_ALU   = 2'd1;
  localparam logic [1:0] OP_LOAD  = 2'd2;
  localparam logic [1:0] OP_STORE = 2'd3;

  logic [2:0]             state_reg;
  logic [INSTR_WIDTH-1:0] ir_reg;
  logic [DATA_WIDTH-1:0]  regs [NREGS];
  logic [DATA_WIDTH-1:0]  mem  [DEPTH];
  logic [DATA_WIDTH-1:0]  opa_reg, opb_reg, opc_reg, res_reg, mdr_reg;
  logic [ADDR_BITS-1:0]   addr_reg;
  logic                   alu_en_reg;
  logic                   retire_reg;

  logic [1:0]            op;
  logic [REG_BITS-1:0]   x1, x2, x3;
  logic [DATA_WIDTH-1:0] imm;
  logic [3:0]            funct;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_en;
  logic                  wb_we;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  mem_we;

  assign op    = ir_reg[OP_LSB +: 2];
  assign x1    = ir_reg[X1_LSB +: REG_BITS];
  assign x2    = ir_reg[X2_LSB +: REG_BITS];
  assign x3    = ir_reg[X3_LSB +: REG_BITS];
  assign imm   = ir_reg[4 +: DATA_WIDTH];
  assign funct = ir_reg[3:0];

  assign instr_ready = (state_reg == IDLE);
  assign retire      = retire_reg;
  assign dbg_data    = regs[dbg_sel];

`ifdef SIMPLE_CPU_FLAGS_EN
  logic alu_carry;
`endif

  always_comb begin
    alu_res = '0;
    alu_en  = 1'b1;
`ifdef SIMPLE_CPU_FLAGS_EN
    alu_carry = 1'b0;
`endif
    case (funct)
      4'd0: begin
`ifdef SIMPLE_CPU_FLAGS_EN
        {alu_carry, alu_res} = {1'b0, opa_reg} + {1'b0, opb_reg};
`else
        alu_res = opa_reg + opb_reg;
`endif
      end
      4'd1: begin
        // Borrow falls out as the extra top bit of the widened difference
`ifdef SIMPLE_CPU_FLAGS_EN
        {alu_carry, alu_res} = {1'b0, opa_reg} - {1'b0, opb_reg};
`else
        alu_res = opa_reg - opb_reg;
`endif
      end
      4'd2:    alu_res = opa_reg & opb_reg;
      4'd3:    alu_res = opa_reg | opb_reg;
      4'd4:    alu_res = opa_reg ^ opb_reg;
      default: alu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      ir_reg     <= '0;
      opa_reg    <= '0;
      opb_reg    <= '0;
      opc_reg    <= '0;
      res_reg    <= '0;
      mdr_reg    <= '0;
      addr_reg   <= '0;
      alu_en_reg <= 1'b0;
      retire_reg <= 1'b0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (instr_valid) begin
            ir_reg    <= instr;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          // All operands are latched here, so a destination that aliases a source sees the old value
          opa_reg <= regs[x2];
          opb_reg <= regs[x3];
          opc_reg <= regs[x1];
          if (op == OP_NOP) begin
            state_reg  <= IDLE;
            retire_reg <= 1'b1;
          end else begin
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          if (op == OP_ALU) begin
            res_reg    <= alu_res;
            alu_en_reg <= alu_en;
            state_reg  <= WB;
          end else begin
            addr_reg  <= ADDR_BITS'({1'b0, opa_reg} + {1'b0, imm});
            state_reg <= MEM;
          end
        end
        MEM: begin
          if (op == OP_LOAD) begin
            mdr_reg   <= mem[addr_reg];
            state_reg <= WB;
          end else begin
            state_reg  <= IDLE;
            retire_reg <= 1'b1;
          end
        end
        WB: begin
          state_reg  <= IDLE;
          retire_reg <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign wb_we   = (state_reg == WB) && ((op == OP_LOAD) || ((op == OP_ALU) && alu_en_reg));
  assign wb_data = (op == OP_LOAD) ? mdr_reg : res_reg;
  assign mem_we  = (state_reg == MEM) && (op == OP_STORE);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          regs[gi] <= DATA_WIDTH'(gi);
        else if (wb_we && (x1 == REG_BITS'(gi)))
          regs[gi] <= wb_data;
      end
    end
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          mem[gi] <= '0;
        else if (mem_we && (addr_reg == ADDR_BITS'(gi)))
          mem[gi] <= opc_reg;
      end
    end
  endgenerate

`ifdef SIMPLE_CPU_FLAGS_EN
  logic res_carry_reg;
  logic zero_flag_reg;
  logic carry_flag_reg;

  // Flags only move on a real ALU write-back; memory ops and NOPs leave them alone
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_carry_reg  <= 1'b0;
      zero_flag_reg  <= 1'b0;
      carry_flag_reg <= 1'b0;
    end else begin
      if (state_reg == EXEC)
        res_carry_reg <= alu_carry;
      if ((state_reg == WB) && (op == OP_ALU) && alu_en_reg) begin
        zero_flag_reg  <= (res_reg == '0);
        carry_flag_reg <= res_carry_reg;
      end
    end
  end

  assign zero_flag  = zero_flag_reg;
  assign carry_flag = carry_flag_reg;
`else
  assign zero_flag  = 1'b0;
  assign carry_flag = 1'b0;
`endif

endmodule

// File: tb/tb_simple_cpu_mc.sv
// Self-checking bench for simple_cpu_mc: directed vector table, multi-cycle corner sequences,
// and random instructions checked against an arithmetic reference model.
module tb_simple_cpu_mc;

  logic        clk;
  logic        rst;
  logic [19:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        retire;
  logic [1:0]  dbg_sel;
  logic [7:0]  dbg_data;
  logic        zero_flag;
  logic        carry_flag;

  int total;
  int bad;

  int m_reg [4];
  int m_mem [32];
  int m_z;
  int m_c;

  typedef struct {
    logic [19:0] ins;
    int          chk_reg;
    int          exp_val;
    int          exp_lat;
    int          exp_z;
    int          exp_c;
  } vec_t;

  vec_t vecs [15];

  simple_cpu_mc dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .retire      (retire),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] enc(input int op, input int x1, input int x2, input int x3,
                                      input int imm, input int f);
    logic [31:0] o, a, b, c, i, fn;
    o = op; a = x1; b = x2; c = x3; i = imm; fn = f;
    return {o[1:0], a[1:0], b[1:0], c[1:0], i[7:0], fn[3:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = i;
    for (int i = 0; i < 32; i++) m_mem[i] = 0;
    m_z = 0;
    m_c = 0;
  endtask

  // Reference semantics straight from the instruction rules, no notion of pipeline states
  task automatic model_exec(input logic [19:0] ins, output int lat);
    int op, x1, x2, x3, imm, f, a, b, r, cy, ok;
    op = int'(ins[19:18]); x1 = int'(ins[17:16]); x2 = int'(ins[15:14]);
    x3 = int'(ins[13:12]); imm = int'(ins[11:4]); f = int'(ins[3:0]);
    lat = 1;
    case (op)
      1: begin
        lat = 3;
        a = m_reg[x2]; b = m_reg[x3]; ok = 1; r = 0; cy = 0;
        case (f)
          0: begin r = (a + b) % 256; cy = (a + b > 255) ? 1 : 0; end
          1: begin r = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
          2: r = a & b;
          3: r = a | b;
          4: r = a ^ b;
          default: ok = 0;
        endcase
        if (ok != 0) begin
          m_reg[x1] = r;
          m_z = (r == 0) ? 1 : 0;
          m_c = cy;
        end
      end
      2: begin
        lat = 4;
        m_reg[x1] = m_mem[(m_reg[x2] + imm) % 32];
      end
      3: begin
        lat = 3;
        m_mem[(m_reg[x2] + imm) % 32] = m_reg[x1];
      end
      default: lat = 1;
    endcase
  endtask

  task automatic rd(input int r, output int v);
    logic [31:0] rr;
    rr = r;
    dbg_sel = rr[1:0];
    #1;
    v = int'(dbg_data);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic check_all(input string tag);
    int v, ez, ec;
    for (int r = 0; r < 4; r++) begin
      rd(r, v);
      chk($sformatf("%s_r%0d", tag, r), v, m_reg[r]);
    end
`ifdef SIMPLE_CPU_FLAGS_EN
    ez = m_z; ec = m_c;
`else
    ez = 0; ec = 0;
`endif
    chk({tag, "_zero"}, int'(zero_flag), ez);
    chk({tag, "_carry"}, int'(carry_flag), ec);
  endtask

  // Issue one instruction and observe retire timing and ready-low cycles over a fixed window
  task automatic run_instr(input logic [19:0] ins, output int lat, output int low);
    int n, seen;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", int'(instr_ready), 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 20'($urandom);
    lat = -1;
    seen = 0;
    low = (instr_ready == 1'b0) ? 1 : 0;
    if (retire) seen++;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      if (retire) begin
        seen++;
        if (lat < 0) lat = c;
      end
      if (!instr_ready) low++;
    end
    if (seen > 1) lat = 100 + seen;
  endtask

  initial begin
    int v, lat, low, exp_lat, ez, ec, rsum;
    int r0h [9];
    int r1h [9];
    int rdy [9];
    int ret [9];
    logic [19:0] rins;
    total = 0;
    bad = 0;
    rst = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    dbg_sel = '0;

    // ---- reset state ----
    apply_reset();
    #1;
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_retire", int'(retire), 0);
    check_all("rst");

    // ---- held valid with changing instr; exact write timing of ADD ----
    @(negedge clk);
    instr = enc(1, 0, 1, 3, 0, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr = enc(1, 1, 1, 3, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      ret[c] = int'(retire);
      rdy[c] = int'(instr_ready);
      rd(0, r0h[c]);
      rd(1, r1h[c]);
      if (c == 4) instr_valid = 1'b0;
    end
    chk("hold_r0_at_A2", r0h[2], 0);
    chk("hold_r0_at_A3", r0h[3], 4);
    chk("hold_r1_busy", r1h[6], 1);
    chk("hold_r1_at_A7", r1h[7], 4);
    chk("hold_ready_A3", rdy[3], 1);
    chk("hold_ready_A4", rdy[4], 0);
    chk("hold_retire_A3", ret[3], 1);
    chk("hold_retire_A7", ret[7], 1);
    rsum = 0;
    for (int c = 1; c <= 8; c++) rsum += ret[c];
    chk("hold_retire_count", rsum, 2);
    $display("txn hold_valid r0=%0d r1=%0d retires=%0d", r0h[8], r1h[8], rsum);

    // ---- reset during EXEC of ADD r0 ----
    apply_reset();
    @(negedge clk);
    instr = enc(1, 0, 1, 3, 0, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    rsum = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (retire) rsum++;
    end
    chk("abort_retire", rsum, 0);
    chk("abort_ready", int'(instr_ready), 1);
    model_reset();
    check_all("abort");
    $display("txn reset_abort retires=%0d", rsum);

    // ---- directed table ----
    vecs[0]  = '{enc(1, 0, 1, 3, 0, 0),  0, 4,   3, 0, 0};
    vecs[1]  = '{enc(1, 2, 0, 2, 0, 1),  2, 2,   3, 0, 0};
    vecs[2]  = '{enc(1, 0, 1, 3, 0, 1),  0, 254, 3, 0, 1};
    vecs[3]  = '{enc(3, 1, 3, 0, 30, 0), -1, 0,  3, 0, 1};
    vecs[4]  = '{enc(2, 0, 3, 0, 30, 0), 0, 1,   4, 0, 1};
    vecs[5]  = '{enc(1, 1, 1, 3, 0, 0),  1, 4,   3, 0, 0};
    vecs[6]  = '{enc(1, 1, 1, 3, 0, 0),  1, 7,   3, 0, 0};
    vecs[7]  = '{enc(3, 1, 2, 0, 15, 0), -1, 0,  3, 0, 0};
    vecs[8]  = '{enc(2, 3, 2, 0, 15, 0), 3, 7,   4, 0, 0};
    vecs[9]  = '{enc(1, 0, 0, 2, 0, 2),  0, 0,   3, 1, 0};
    vecs[10] = '{enc(0, 0, 0, 0, 0, 0),  -1, 0,  1, 1, 0};
    vecs[11] = '{enc(1, 2, 2, 2, 0, 4),  2, 0,   3, 1, 0};
    vecs[12] = '{enc(1, 3, 3, 3, 0, 0),  3, 14,  3, 0, 0};
    vecs[13] = '{enc(1, 0, 3, 2, 0, 3),  0, 14,  3, 0, 0};
    vecs[14] = '{enc(1, 1, 0, 0, 0, 5),  1, 7,   3, 0, 0};
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      run_instr(vecs[i].ins, lat, low);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_ready_low", i), low, vecs[i].exp_lat);
      if (vecs[i].chk_reg >= 0) begin
        rd(vecs[i].chk_reg, v);
        chk($sformatf("vec%0d_r%0d", i, vecs[i].chk_reg), v, vecs[i].exp_val);
      end
`ifdef SIMPLE_CPU_FLAGS_EN
      ez = vecs[i].exp_z; ec = vecs[i].exp_c;
`else
      ez = 0; ec = 0;
`endif
      chk($sformatf("vec%0d_zero", i), int'(zero_flag), ez);
      chk($sformatf("vec%0d_carry", i), int'(carry_flag), ec);
      $display("txn vec%0d instr=%05h lat=%0d", i, vecs[i].ins, lat);
    end

    // ---- random instructions vs. reference model ----
    apply_reset();
    for (int i = 0; i < 150; i++) begin
      rins = enc($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 7));
      model_exec(rins, exp_lat);
      run_instr(rins, lat, low);
      chk($sformatf("rnd%0d_latency", i), lat, exp_lat);
      chk($sformatf("rnd%0d_ready_low", i), low, exp_lat);
      check_all($sformatf("rnd%0d", i));
      $display("txn rnd%0d instr=%05h lat=%0d", i, rins, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
